// File: rtl/stroke_phase_timer.sv
// stroke_phase_timer
//   Tracks the rowing stroke phase (IDLE / DRIVE / RECOVERY) from catch and
//   finish event pulses, times each phase with saturating counters, ignores
//   exit events that arrive before a phase has lasted MIN_PHASE cycles, and
//   latches drive/recovery durations once per completed stroke.
//   Optional build macro: IDLE_TIMEOUT_EN. When defined, a recovery lasting
//   TIMEOUT cycles without a catch returns the tracker to IDLE.
module stroke_phase_timer #(
    parameter int CW        = 32,
    parameter int SCW       = 16,
    parameter int MIN_PHASE = 4,
    parameter int TIMEOUT   = 2**20
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start_drive,
    input  logic           start_recovery,
    output logic [1:0]     phase,
    output logic [CW-1:0]  drive_count,
    output logic [CW-1:0]  recovery_count,
    output logic [CW-1:0]  last_drive,
    output logic [CW-1:0]  last_recovery,
    output logic           stroke_valid,
    output logic [SCW-1:0] stroke_count,
    output logic           sat
);

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        DRIVE    = 2'b01,
        RECOVERY = 2'b10
    } phase_e;

    localparam logic [CW-1:0] MAX_C = '1;
    localparam logic [CW-1:0] MIN_C = CW'(MIN_PHASE);

`ifdef IDLE_TIMEOUT_EN
    // A TIMEOUT that does not fit in CW bits can never be reached; the
    // counter saturates first, so the comparison is disabled outright.
    localparam bit            TIMEOUT_FITS = (TIMEOUT >= 0) && ((longint'(TIMEOUT) >> CW) == 0);
    localparam logic [CW-1:0] TIMEOUT_C    = CW'(TIMEOUT);
`endif

    // Parameter sanity: an elaborated g_illegal_params scope in the netlist
    // hierarchy marks an unusable configuration (MIN_PHASE or TIMEOUT < 1).
    if (MIN_PHASE < 1 || TIMEOUT < 1) begin : g_illegal_params
    end

    phase_e         phase_q, phase_d;
    logic [CW-1:0]  drive_count_q, drive_count_d;
    logic [CW-1:0]  recovery_count_q, recovery_count_d;
    logic [CW-1:0]  last_drive_q, last_drive_d;
    logic [CW-1:0]  last_recovery_q, last_recovery_d;
    logic           stroke_valid_q, stroke_valid_d;
    logic [SCW-1:0] stroke_count_q, stroke_count_d;
    logic           sat_q, sat_d;

    logic ev_drive;
    logic ev_recovery;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == MAX_C) ? v : v + CW'(1);
    endfunction

    // Next-state logic: phase transitions, counter updates and stroke latching.
    always_comb begin
        // NOTE: every signal gets a default first so no path through the case
        // leaves it unassigned, which would otherwise infer a latch.
        phase_d          = phase_q;
        drive_count_d    = drive_count_q;
        recovery_count_d = recovery_count_q;
        last_drive_d     = last_drive_q;
        last_recovery_d  = last_recovery_q;
        stroke_valid_d   = 1'b0;
        stroke_count_d   = stroke_count_q;
        sat_d            = sat_q;

        // Simultaneous catch and finish is treated as noise.
        ev_drive    = start_drive & ~start_recovery;
        ev_recovery = start_recovery & ~start_drive;

        unique case (phase_q)
            IDLE: begin
                if (ev_drive) begin
                    phase_d       = DRIVE;
                    drive_count_d = CW'(1);
                end
            end
            DRIVE: begin
                if (ev_recovery && drive_count_q >= MIN_C) begin
                    phase_d          = RECOVERY;
                    recovery_count_d = CW'(1);
                end else begin
                    drive_count_d = sat_inc(drive_count_q);
                end
            end
            RECOVERY: begin
                if (ev_drive && recovery_count_q >= MIN_C) begin
                    last_drive_d    = drive_count_q;
                    last_recovery_d = recovery_count_q;
                    stroke_count_d  = stroke_count_q + SCW'(1);
                    sat_d           = (drive_count_q == MAX_C) || (recovery_count_q == MAX_C);
                    stroke_valid_d  = 1'b1;
                    phase_d         = DRIVE;
                    drive_count_d   = CW'(1);
                end
`ifdef IDLE_TIMEOUT_EN
                else if (TIMEOUT_FITS && recovery_count_q == TIMEOUT_C) begin
                    // Abandoned stroke: park in IDLE with the live counts frozen.
                    phase_d = IDLE;
                end
`endif
                else begin
                    recovery_count_d = sat_inc(recovery_count_q);
                end
            end
            default: begin
                phase_d = IDLE;
            end
        endcase
    end

    // State register; reset discards any partial stroke immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_q          <= IDLE;
            drive_count_q    <= '0;
            recovery_count_q <= '0;
            last_drive_q     <= '0;
            last_recovery_q  <= '0;
            stroke_valid_q   <= 1'b0;
            stroke_count_q   <= '0;
            sat_q            <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge values regardless of statement order.
            phase_q          <= phase_d;
            drive_count_q    <= drive_count_d;
            recovery_count_q <= recovery_count_d;
            last_drive_q     <= last_drive_d;
            last_recovery_q  <= last_recovery_d;
            stroke_valid_q   <= stroke_valid_d;
            stroke_count_q   <= stroke_count_d;
            sat_q            <= sat_d;
        end
    end

    assign phase          = phase_q;
    assign drive_count    = drive_count_q;
    assign recovery_count = recovery_count_q;
    assign last_drive     = last_drive_q;
    assign last_recovery  = last_recovery_q;
    assign stroke_valid   = stroke_valid_q;
    assign stroke_count   = stroke_count_q;
    assign sat            = sat_q;

endmodule

// File: tb/tb_stroke_phase_timer.sv
// Testbench for stroke_phase_timer: directed scenarios with literal
// expectations plus randomized event streams, all compared every cycle
// against a timestamp-based model of phase durations.
module tb_stroke_phase_timer;

    localparam int CW        = 8;
    localparam int SCW       = 3;
    localparam int MIN_PHASE = 4;
    localparam int TIMEOUT   = 200;
    localparam int MAXV      = (1 << CW) - 1;

    logic           clk;
    logic           reset;
    logic           start_drive;
    logic           start_recovery;
    logic [1:0]     phase;
    logic [CW-1:0]  drive_count;
    logic [CW-1:0]  recovery_count;
    logic [CW-1:0]  last_drive;
    logic [CW-1:0]  last_recovery;
    logic           stroke_valid;
    logic [SCW-1:0] stroke_count;
    logic           sat;

    int tests_run;
    int tests_failed;

    stroke_phase_timer #(
        .CW(CW), .SCW(SCW), .MIN_PHASE(MIN_PHASE), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start_drive(start_drive),
        .start_recovery(start_recovery),
        .phase(phase),
        .drive_count(drive_count),
        .recovery_count(recovery_count),
        .last_drive(last_drive),
        .last_recovery(last_recovery),
        .stroke_valid(stroke_valid),
        .stroke_count(stroke_count),
        .sat(sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // Phases are described by the edge index at which they were entered and
    // (once left) exited; live counts are derived from those timestamps.
    int n;                       // index of the next clock edge
    int m_phase;                 // 0 idle, 1 drive, 2 recovery
    int d_entry, d_exit, r_entry, r_exit;
    int m_last_d, m_last_r, m_scount, m_sat, m_valid;

    function automatic int min_i(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // Counter value just after edge 'at'.
    function automatic int cnt(input int entry, input int ex, input int at);
        if (entry < 0) return 0;
        if (ex >= 0) return min_i(ex - entry, MAXV);
        return min_i(at - entry + 1, MAXV);
    endfunction

    task automatic model_reset();
        m_phase = 0;
        d_entry = -1; d_exit = -1; r_entry = -1; r_exit = -1;
        m_last_d = 0; m_last_r = 0; m_scount = 0; m_sat = 0; m_valid = 0;
    endtask

    task automatic model_step(input logic sd, input logic sr);
        int dc, rc;
        bit ed, er;
        dc = cnt(d_entry, d_exit, n - 1);
        rc = cnt(r_entry, r_exit, n - 1);
        ed = sd && !sr;
        er = sr && !sd;
        m_valid = 0;
        if (m_phase == 0) begin
            if (ed) begin
                m_phase = 1; d_entry = n; d_exit = -1;
            end
        end else if (m_phase == 1) begin
            if (er && dc >= MIN_PHASE) begin
                m_phase = 2; d_exit = n; r_entry = n; r_exit = -1;
            end
        end else begin
            if (ed && rc >= MIN_PHASE) begin
                m_last_d = dc;
                m_last_r = rc;
                m_scount = (m_scount + 1) % (1 << SCW);
                m_sat    = (dc == MAXV || rc == MAXV) ? 1 : 0;
                m_valid  = 1;
                m_phase  = 1; r_exit = n; d_entry = n; d_exit = -1;
            end
`ifdef IDLE_TIMEOUT_EN
            else if (rc == TIMEOUT) begin
                m_phase = 0; r_exit = n;
            end
`endif
        end
        n = n + 1;
    endtask

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s at t=%0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic compare_all();
        check("phase",          64'(phase),          64'(m_phase));
        check("drive_count",    64'(drive_count),    64'(cnt(d_entry, d_exit, n - 1)));
        check("recovery_count", 64'(recovery_count), 64'(cnt(r_entry, r_exit, n - 1)));
        check("last_drive",     64'(last_drive),     64'(m_last_d));
        check("last_recovery",  64'(last_recovery),  64'(m_last_r));
        check("stroke_valid",   64'(stroke_valid),   64'(m_valid));
        check("stroke_count",   64'(stroke_count),   64'(m_scount));
        check("sat",            64'(sat),            64'(m_sat));
    endtask

    // One clock: inputs applied at the falling edge, outputs compared at the next one.
    task automatic cycle(input logic sd, input logic sr);
        start_drive    = sd;
        start_recovery = sr;
        model_step(sd, sr);
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) cycle(1'b0, 1'b0);
    endtask

    // Asynchronous reset pulse raised between clock edges; outputs are
    // checked while reset is high, before any clock edge arrives.
    task automatic reset_pulse();
        start_drive    = 1'b0;
        start_recovery = 1'b0;
        #2 reset = 1'b1;
        #1;
        model_reset();
        compare_all();
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int den, r, kind;
        tests_run    = 0;
        tests_failed = 0;
        n            = 0;
        reset        = 1'b1;
        start_drive  = 1'b0;
        start_recovery = 1'b0;
        model_reset();
        @(negedge clk);
        compare_all();
        check("reset_phase_lit", 64'(phase), 64'd0);
        reset = 1'b0;

        // Nominal stroke: drive at edge 0, finish at 10, catch at 30.
        cycle(1'b1, 1'b0);
        idle(9);
        cycle(1'b0, 1'b1);
        idle(19);
        cycle(1'b1, 1'b0);
        check("nom_last_drive",    64'(last_drive),    64'd10);
        check("nom_last_recovery", 64'(last_recovery), 64'd20);
        check("nom_valid",         64'(stroke_valid),  64'd1);
        check("nom_count",         64'(stroke_count),  64'd1);
        check("nom_phase",         64'(phase),         64'd1);
        check("nom_drive_count",   64'(drive_count),   64'd1);
        idle(1);
        check("nom_valid_drop",    64'(stroke_valid),  64'd0);

        // Async reset mid-DRIVE clears everything without a clock edge.
        idle(3);
        reset_pulse();
        check("rst_phase_lit", 64'(phase), 64'd0);

        // Debounce of short drive and short recovery.
        cycle(1'b1, 1'b0);
        idle(1);
        cycle(1'b0, 1'b1);
        check("deb_short_drive", 64'(phase), 64'd1);
        idle(1);
        cycle(1'b0, 1'b1);
        check("deb_enter_rec", 64'(phase), 64'd2);
        idle(1);
        cycle(1'b1, 1'b0);
        check("deb_short_rec", 64'(phase), 64'd2);
        check("deb_no_valid",  64'(stroke_valid), 64'd0);

        // Drive saturation.
        reset_pulse();
        cycle(1'b1, 1'b0);
        idle(299);
        check("sat_drive_hold", 64'(drive_count), 64'(MAXV));
        check("sat_phase",      64'(phase), 64'd1);
        cycle(1'b0, 1'b1);
        idle(4);
        cycle(1'b1, 1'b0);
        check("sat_last_drive",    64'(last_drive),    64'(MAXV));
        check("sat_last_recovery", 64'(last_recovery), 64'd5);
        check("sat_flag",          64'(sat),           64'd1);

        // Conflicting events in DRIVE, stray finish in IDLE.
        cycle(1'b1, 1'b1);
        check("conflict_phase", 64'(phase), 64'd1);
        reset_pulse();
        cycle(1'b0, 1'b1);
        check("stray_idle", 64'(phase), 64'd0);

        // Stroke counter wrap: 2^SCW minimum-length strokes.
        cycle(1'b1, 1'b0);
        for (int s = 0; s < (1 << SCW); s++) begin
            idle(3);
            cycle(1'b0, 1'b1);
            idle(3);
            cycle(1'b1, 1'b0);
        end
        check("wrap_count",      64'(stroke_count), 64'd0);
        check("wrap_last_drive", 64'(last_drive),   64'd4);
        check("wrap_sat_clear",  64'(sat),          64'd0);

        // Long recovery without a catch.
        reset_pulse();
        cycle(1'b1, 1'b0);
        idle(3);
        cycle(1'b0, 1'b1);
        idle(210);
`ifdef IDLE_TIMEOUT_EN
        check("timeout_phase", 64'(phase),          64'd0);
        check("timeout_count", 64'(recovery_count), 64'(TIMEOUT));
`else
        check("timeout_phase", 64'(phase),          64'd2);
        check("timeout_count", 64'(recovery_count), 64'd211);
`endif
        check("timeout_no_stroke", 64'(stroke_count), 64'd0);

        // Randomized event streams at varying event densities.
        for (int seg = 0; seg < 30; seg++) begin
            case ($urandom_range(0, 3))
                0:       den = 3;
                1:       den = 8;
                2:       den = 40;
                default: den = 500;
            endcase
            for (int c = 0; c < 500; c++) begin
                if ($urandom_range(0, 2999) == 0) begin
                    reset_pulse();
                end else begin
                    r = $urandom_range(0, den - 1);
                    if (r != 0) begin
                        cycle(1'b0, 1'b0);
                    end else begin
                        kind = $urandom_range(0, 9);
                        if (kind == 0)      cycle(1'b1, 1'b1);
                        else if (kind <= 5) cycle(1'b1, 1'b0);
                        else                cycle(1'b0, 1'b1);
                    end
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
